csr_excp_unit: RTL and testbench
================================

Name: csr_excp_unit

Overview:
- Control/status register file and exception-entry controller for the LoongArch pipeline.
- Receives the write-back stage's exception, ertn and CSR-write interface.
- Updates CRMD, PRMD, ESTAT, ERA and BADV accordingly.
- Issues a registered fetch redirect, runs the architectural timer, and raises the interrupt request sampled by decode.

Parameters:
- TLBR_ECODE, 6'h3F, Ecode value meaning TLB refill; checked on ertn.
- CSR_RESET_CRMD, 32'h0000_0008, CRMD reset value (DA=1, PLV=0, IE=0).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- excp_flush  in  1  exception commit from write-back
- ertn_flush  in  1  ertn commit
- csr_ecode  in  6  exception code
- csr_esubcode  in  9  exception subcode
- csr_era  in  32  PC of the excepting instruction
- va_error  in  1  bad_va is valid
- bad_va  in  32  faulting address
- excp_tlbrefill  in  1  exception is a TLB refill
- csr_wr_en  in  1  CSR write strobe
- wr_csr_addr  in  14  CSR write index
- wr_csr_data  in  32  CSR write data
- rd_csr_addr  in  14  CSR read index
- rd_csr_data  out  32  CSR read data (combinational)
- hw_int_in  in  8  external interrupt lines
- ipi_int_in  in  1  inter-processor interrupt
- has_int  out  1  interrupt pending and enabled (registered)
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  32  redirect target
- crmd_plv  out  2  current privilege level
- timer_64  out  64  stable counter

Behaviour:
- Implemented CSRs (index):
  - CRMD 0x0: PLV[1:0], IE[2], DA[3], PG[4]
  - PRMD 0x1: PPLV[1:0], PIE[2]
  - ECFG 0x4: LIE[12:0], bits 10 and 31:13 read 0
  - ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22]
  - ERA 0x6, BADV 0x7
  - EENTRY 0xC: [31:6] writable
  - SAVE0-3 0x30-0x33
  - TID 0x40
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2]
  - TVAL 0x42: read-only
  - TICLR 0x44: write-only, reads 0
  - TLBRENTRY 0x88: [31:6] writable
- Unmapped indices read 0; writes to them are ignored. Non-writable fields ignore written data.
- Reset: CRMD=CSR_RESET_CRMD; all other CSRs, TVAL and timer_64 = 0; redirect_valid=0, redirect_pc=0, has_int=0.
- Same-cycle priority: excp_flush > ertn_flush > csr_wr_en. The lower-priority event is dropped entirely.
- Exception edge:
  - PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0; CRMD.IE<=0.
  - If excp_tlbrefill: CRMD.DA<=1, CRMD.PG<=0.
  - ERA<=csr_era; ESTAT.Ecode<=csr_ecode; ESTAT.EsubCode<=csr_esubcode.
  - BADV<=bad_va only if va_error.
  - Next cycle: redirect_valid=1, redirect_pc = TLBRENTRY if excp_tlbrefill, else EENTRY. Both take their pre-edge value.
- ertn edge:
  - CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
  - If ESTAT.Ecode==TLBR_ECODE: CRMD.DA<=0, CRMD.PG<=1.
  - Next cycle: redirect_valid=1, redirect_pc=ERA.
- redirect_valid lasts exactly one cycle. Back-to-back flushes produce back-to-back pulses.
- CSR write takes effect at the edge. A same-cycle read returns the old value; there is no bypass.
- ESTAT.IS:
  - IS[1:0] are software-writable.
  - IS[9:2]<=hw_int_in every cycle.
  - IS[12]<=ipi_int_in every cycle.
  - IS[11] is the timer flag.
- has_int <= CRMD.IE & |(ESTAT.IS & ECFG.LIE). It uses registered state, so the latency is 1 cycle after the IS/IE/LIE change is visible.
- Timer:
  - A write to TCFG loads TVAL={wr_data[31:2],2'b00}.
  - When En=1 and TVAL!=0, TVAL decrements by 1 per cycle.
  - The transition TVAL 1->0 sets IS[11].
  - With TVAL==0, En=1 and Periodic=1, TVAL reloads {InitVal,2'b00}.
  - With Periodic=0, TVAL holds 0.
  - Writing TICLR with bit0=1 clears IS[11]. If a set occurs in the same cycle, the set wins.
- timer_64 increments every cycle and wraps at 2^64.
- crmd_plv = CRMD.PLV.

Optional Feature:
- Macro: CSR_TIMER_EN.
- Defined: TCFG/TVAL/TICLR/TID and the timer logic behave as above.
- Undefined:
  - These indices read 0 and ignore writes.
  - IS[11] is constant 0.
  - timer_64 still counts.

Test Plan:
- After reset, read CRMD -> 32'h8. Read ESTAT/ERA -> 0. has_int=0, redirect_valid=0.
- Write EENTRY=0x1C00_8000, CRMD.PLV=3/IE=1. Then excp_flush with ecode=0x0B, era=0x1C00_0100 -> next cycle redirect_valid=1, redirect_pc=0x1C00_8000. ERA=0x1C00_0100, PRMD=0x7, CRMD.PLV=0/IE=0.
- Then ertn_flush -> redirect_pc=0x1C00_0100, CRMD.PLV=3, IE=1.
- TLB refill: TLBRENTRY=0x1C00_F000, excp_tlbrefill=1, ecode=0x3F, va_error=1, bad_va=0x8000_1234 -> redirect_pc=0x1C00_F000, BADV=0x8000_1234, DA=1/PG=0. A following ertn sets DA=0/PG=1.
- Timer, CSR_TIMER_EN defined: write TCFG=0x0000_0013 (InitVal=4, periodic) with ECFG.LIE[11]=1, IE=1 -> IS[11] set 16 cycles after write, has_int=1 the cycle after. Write TICLR=1 -> IS[11] cleared, TVAL reloaded to 16.
- Same-cycle excp_flush and csr_wr_en to SAVE0=0xDEAD -> SAVE0 unchanged, exception processed. hw_int_in=0x01 with LIE[2]=1 -> has_int=1 two cycles later.

Source files
------------

// File: rtl/csr_excp_unit.sv
// csr_excp_unit: LoongArch CSR file, exception entry/return and redirect.
// Timer CSRs (TID/TCFG/TVAL/TICLR) exist only when CSR_TIMER_EN is defined.
module csr_excp_unit #(
  parameter logic [5:0]  TLBR_ECODE     = 6'h3F,
  parameter logic [31:0] CSR_RESET_CRMD = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [5:0]  csr_ecode,
  input  logic [8:0]  csr_esubcode,
  input  logic [31:0] csr_era,
  input  logic        va_error,
  input  logic [31:0] bad_va,
  input  logic        excp_tlbrefill,
  input  logic        csr_wr_en,
  input  logic [13:0] wr_csr_addr,
  input  logic [31:0] wr_csr_data,
  input  logic [13:0] rd_csr_addr,
  output logic [31:0] rd_csr_data,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic        has_int,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  crmd_plv,
  output logic [63:0] timer_64
);

  localparam logic [13:0] A_CRMD      = 14'h000;
  localparam logic [13:0] A_PRMD      = 14'h001;
  localparam logic [13:0] A_ECFG      = 14'h004;
  localparam logic [13:0] A_ESTAT     = 14'h005;
  localparam logic [13:0] A_ERA       = 14'h006;
  localparam logic [13:0] A_BADV      = 14'h007;
  localparam logic [13:0] A_EENTRY    = 14'h00C;
  localparam logic [13:0] A_SAVE0     = 14'h030;
  localparam logic [13:0] A_SAVE1     = 14'h031;
  localparam logic [13:0] A_SAVE2     = 14'h032;
  localparam logic [13:0] A_SAVE3     = 14'h033;
  localparam logic [13:0] A_TID       = 14'h040;
  localparam logic [13:0] A_TCFG      = 14'h041;
  localparam logic [13:0] A_TVAL      = 14'h042;
  localparam logic [13:0] A_TLBRENTRY = 14'h088;

  logic [1:0]  plv;
  logic        ie;
  logic        da;
  logic        pg;
  logic [1:0]  pplv;
  logic        pie;
  logic [12:0] lie;
  logic [12:0] estat_is;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [25:0] tlbrentry;
  logic [31:0] save0;
  logic [31:0] save1;
  logic [31:0] save2;
  logic [31:0] save3;
  logic [31:0] tid;
  logic        tcfg_en;
  logic        tcfg_per;
  logic [29:0] tcfg_init;
  logic [31:0] tval;
  logic        timer_set;
  logic        ticlr_clr;

  assign crmd_plv = plv;

`ifdef CSR_TIMER_EN
  localparam logic [13:0] A_TICLR = 14'h044;

  logic wr_ok;
  logic wr_tcfg;

  // A flush in the same cycle drops the CSR write entirely
  assign wr_ok     = csr_wr_en && !excp_flush && !ertn_flush;
  assign wr_tcfg   = wr_ok && (wr_csr_addr == A_TCFG);
  assign ticlr_clr = wr_ok && (wr_csr_addr == A_TICLR) && wr_csr_data[0];
  assign timer_set = tcfg_en && (tval == 32'd1) && !wr_tcfg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tid       <= '0;
      tcfg_en   <= 1'b0;
      tcfg_per  <= 1'b0;
      tcfg_init <= '0;
      tval      <= '0;
    end else begin
      if (wr_ok && (wr_csr_addr == A_TID))
        tid <= wr_csr_data;
      if (wr_tcfg) begin
        tcfg_en   <= wr_csr_data[0];
        tcfg_per  <= wr_csr_data[1];
        tcfg_init <= wr_csr_data[31:2];
        tval      <= {wr_csr_data[31:2], 2'b00};
      end else if (tcfg_en) begin
        if (tval != '0)
          tval <= tval - 32'd1;
        else if (tcfg_per)
          tval <= {tcfg_init, 2'b00};
      end
    end
  end
`else
  assign tid       = '0;
  assign tcfg_en   = 1'b0;
  assign tcfg_per  = 1'b0;
  assign tcfg_init = '0;
  assign tval      = '0;
  assign timer_set = 1'b0;
  assign ticlr_clr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      plv            <= CSR_RESET_CRMD[1:0];
      ie             <= CSR_RESET_CRMD[2];
      da             <= CSR_RESET_CRMD[3];
      pg             <= CSR_RESET_CRMD[4];
      pplv           <= '0;
      pie            <= 1'b0;
      lie            <= '0;
      estat_is       <= '0;
      ecode          <= '0;
      esubcode       <= '0;
      era            <= '0;
      badv           <= '0;
      eentry         <= '0;
      tlbrentry      <= '0;
      save0          <= '0;
      save1          <= '0;
      save2          <= '0;
      save3          <= '0;
      has_int        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      timer_64       <= '0;
    end else begin
      timer_64       <= timer_64 + 64'd1;
      estat_is[9:2]  <= hw_int_in;
      estat_is[10]   <= 1'b0;
      estat_is[11]   <= timer_set | (estat_is[11] & ~ticlr_clr);
      estat_is[12]   <= ipi_int_in;
      has_int        <= ie & (|(estat_is & lie));
      redirect_valid <= excp_flush | ertn_flush;
      if (excp_flush) begin
        pplv     <= plv;
        pie      <= ie;
        plv      <= 2'd0;
        ie       <= 1'b0;
        era      <= csr_era;
        ecode    <= csr_ecode;
        esubcode <= csr_esubcode;
        if (excp_tlbrefill) begin
          da <= 1'b1;
          pg <= 1'b0;
        end
        if (va_error)
          badv <= bad_va;
        redirect_pc <= excp_tlbrefill ? {tlbrentry, 6'b0}
                                      : {eentry, 6'b0};
      end else if (ertn_flush) begin
        plv <= pplv;
        ie  <= pie;
        if (ecode == TLBR_ECODE) begin
          da <= 1'b0;
          pg <= 1'b1;
        end
        redirect_pc <= era;
      end else if (csr_wr_en) begin
        unique case (wr_csr_addr)
          A_CRMD: begin
            plv <= wr_csr_data[1:0];
            ie  <= wr_csr_data[2];
            da  <= wr_csr_data[3];
            pg  <= wr_csr_data[4];
          end
          A_PRMD: begin
            pplv <= wr_csr_data[1:0];
            pie  <= wr_csr_data[2];
          end
          A_ECFG:      lie <= wr_csr_data[12:0] & 13'h1BFF;
          A_ESTAT:     estat_is[1:0] <= wr_csr_data[1:0];
          A_ERA:       era <= wr_csr_data;
          A_BADV:      badv <= wr_csr_data;
          A_EENTRY:    eentry <= wr_csr_data[31:6];
          A_SAVE0:     save0 <= wr_csr_data;
          A_SAVE1:     save1 <= wr_csr_data;
          A_SAVE2:     save2 <= wr_csr_data;
          A_SAVE3:     save3 <= wr_csr_data;
          A_TLBRENTRY: tlbrentry <= wr_csr_data[31:6];
          default: ;
        endcase
      end
    end
  end

  // TICLR is write-only and falls through to the default zero
  always_comb begin
    rd_csr_data = '0;
    unique case (rd_csr_addr)
      A_CRMD:      rd_csr_data = {27'b0, pg, da, ie, plv};
      A_PRMD:      rd_csr_data = {29'b0, pie, pplv};
      A_ECFG:      rd_csr_data = {19'b0, lie};
      A_ESTAT:     rd_csr_data = {1'b0, esubcode, ecode, 3'b0, estat_is};
      A_ERA:       rd_csr_data = era;
      A_BADV:      rd_csr_data = badv;
      A_EENTRY:    rd_csr_data = {eentry, 6'b0};
      A_SAVE0:     rd_csr_data = save0;
      A_SAVE1:     rd_csr_data = save1;
      A_SAVE2:     rd_csr_data = save2;
      A_SAVE3:     rd_csr_data = save3;
      A_TID:       rd_csr_data = tid;
      A_TCFG:      rd_csr_data = {tcfg_init, tcfg_per, tcfg_en};
      A_TVAL:      rd_csr_data = tval;
      A_TLBRENTRY: rd_csr_data = {tlbrentry, 6'b0};
      default:     rd_csr_data = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_excp_unit.sv
// tb_csr_excp_unit: table-driven CSR checks plus a redirect scoreboard.
// Timer expectations follow CSR_TIMER_EN.
module tb_csr_excp_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        excp_flush = 1'b0;
  logic        ertn_flush = 1'b0;
  logic [5:0]  csr_ecode = '0;
  logic [8:0]  csr_esubcode = '0;
  logic [31:0] csr_era = '0;
  logic        va_error = 1'b0;
  logic [31:0] bad_va = '0;
  logic        excp_tlbrefill = 1'b0;
  logic        csr_wr_en = 1'b0;
  logic [13:0] wr_csr_addr = '0;
  logic [31:0] wr_csr_data = '0;
  logic [13:0] rd_csr_addr = '0;
  logic [31:0] rd_csr_data;
  logic [7:0]  hw_int_in = '0;
  logic        ipi_int_in = 1'b0;
  logic        has_int;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  crmd_plv;
  logic [63:0] timer_64;

  csr_excp_unit dut (
    .clk(clk), .reset(reset),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .csr_era(csr_era), .va_error(va_error), .bad_va(bad_va),
    .excp_tlbrefill(excp_tlbrefill),
    .csr_wr_en(csr_wr_en), .wr_csr_addr(wr_csr_addr),
    .wr_csr_data(wr_csr_data),
    .rd_csr_addr(rd_csr_addr), .rd_csr_data(rd_csr_data),
    .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .has_int(has_int),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .crmd_plv(crmd_plv), .timer_64(timer_64)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } redir_t;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  redir_t rq[$];
  vec_t   tbl[17];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  logic [63:0] t0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one cycle, then match any redirect pulse against the queue
  task automatic tick();
    redir_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (redirect_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected: got pc %h expected no pulse",
                 redirect_pc);
      end else begin
        e = rq.pop_front();
        if (redirect_pc !== e.pc || cyc != e.due) begin
          errors++;
          $display("FAIL redirect: got pc %h cyc %0d expected pc %h cyc %0d",
                   redirect_pc, cyc, e.pc, e.due);
        end
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      checks++;
      errors++;
      e = rq.pop_front();
      $display("FAIL redirect_missing: got no pulse expected pc %h", e.pc);
    end
  endtask

  task automatic chk_csr(input string name, input logic [13:0] a,
                         input logic [31:0] exp);
    rd_csr_addr = a;
    #1;
    chk(name, {32'h0, rd_csr_data}, {32'h0, exp});
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_wr_en   = 1'b1;
    wr_csr_addr = a;
    wr_csr_data = d;
    tick();
    csr_wr_en   = 1'b0;
  endtask

  task automatic flush(input bit ex, input bit er, input logic [31:0] pc);
    excp_flush = ex;
    ertn_flush = er;
    rq.push_back('{pc, cyc + 1});
    tick();
    excp_flush = 1'b0;
    ertn_flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{14'h000, 32'hFFFF_FFFF, 32'h0000_001F};
    tbl[1]  = '{14'h001, 32'hFFFF_FFFF, 32'h0000_0007};
    tbl[2]  = '{14'h004, 32'hFFFF_FFFF, 32'h0000_1BFF};
    tbl[3]  = '{14'h005, 32'hFFFF_FFFF, 32'h0000_0003};
    tbl[4]  = '{14'h006, 32'h1234_5678, 32'h1234_5678};
    tbl[5]  = '{14'h007, 32'h89AB_CDEF, 32'h89AB_CDEF};
    tbl[6]  = '{14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
    tbl[7]  = '{14'h030, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[8]  = '{14'h033, 32'h0BAD_F00D, 32'h0BAD_F00D};
    tbl[9]  = '{14'h088, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
    tbl[10] = '{14'h002, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[11] = '{14'h3FFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[12] = '{14'h044, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[13] = '{14'h042, 32'hFFFF_FFFF, 32'h0000_0000};
`ifdef CSR_TIMER_EN
    tbl[14] = '{14'h040, 32'hCAFE_0001, 32'hCAFE_0001};
    tbl[15] = '{14'h041, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
`else
    tbl[14] = '{14'h040, 32'hCAFE_0001, 32'h0000_0000};
    tbl[15] = '{14'h041, 32'hFFFF_FFF0, 32'h0000_0000};
`endif
    tbl[16] = '{14'h008, 32'hFFFF_FFFF, 32'h0000_0000};

    do_reset();
    chk_csr("reset_crmd", 14'h000, 32'h8);
    chk_csr("reset_estat", 14'h005, 32'h0);
    chk_csr("reset_era", 14'h006, 32'h0);
    chk("reset_has_int", {63'h0, has_int}, 64'h0);
    chk("reset_redirect", {63'h0, redirect_valid}, 64'h0);
    chk("reset_plv", {62'h0, crmd_plv}, 64'h0);
    chk("reset_timer64", timer_64, 64'h0);
    t0 = timer_64;
    repeat (5) tick();
    chk("timer64_count", timer_64, t0 + 64'd5);

    for (int i = 0; i < 17; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      chk_csr($sformatf("csr_rw_%0d", i), tbl[i].addr, tbl[i].exp);
    end

    csr_wr_en   = 1'b1;
    wr_csr_addr = 14'h031;
    wr_csr_data = 32'h55;
    chk_csr("no_bypass_old", 14'h031, 32'h0);
    tick();
    csr_wr_en = 1'b0;
    chk_csr("no_bypass_new", 14'h031, 32'h55);

    do_reset();
    wr(14'h00C, 32'h1C00_8000);
    wr(14'h000, 32'h0000_000F);
    chk("plv_written", {62'h0, crmd_plv}, 64'd3);
    csr_ecode    = 6'h0B;
    csr_esubcode = 9'h0;
    csr_era      = 32'h1C00_0100;
    va_error     = 1'b0;
    bad_va       = 32'hFFFF_FFFF;
    csr_wr_en    = 1'b1;
    wr_csr_addr  = 14'h030;
    wr_csr_data  = 32'hDEAD;
    flush(1'b1, 1'b0, 32'h1C00_8000);
    csr_wr_en = 1'b0;
    chk_csr("excp_era", 14'h006, 32'h1C00_0100);
    chk_csr("excp_prmd", 14'h001, 32'h7);
    chk_csr("excp_crmd", 14'h000, 32'h8);
    chk_csr("excp_estat", 14'h005, 32'h000B_0000);
    chk_csr("excp_drops_wr", 14'h030, 32'h0);
    chk_csr("excp_badv_gated", 14'h007, 32'h0);
    chk("excp_plv", {62'h0, crmd_plv}, 64'd0);
    flush(1'b0, 1'b1, 32'h1C00_0100);
    chk_csr("ertn_crmd", 14'h000, 32'hF);
    chk("ertn_plv", {62'h0, crmd_plv}, 64'd3);

    wr(14'h088, 32'h1C00_F000);
    excp_tlbrefill = 1'b1;
    csr_ecode      = 6'h3F;
    csr_esubcode   = 9'h1;
    va_error       = 1'b1;
    bad_va         = 32'h8000_1234;
    csr_era        = 32'h1C00_0200;
    flush(1'b1, 1'b0, 32'h1C00_F000);
    excp_tlbrefill = 1'b0;
    va_error       = 1'b0;
    chk_csr("tlbr_crmd", 14'h000, 32'h8);
    chk_csr("tlbr_prmd", 14'h001, 32'h7);
    chk_csr("tlbr_badv", 14'h007, 32'h8000_1234);
    chk_csr("tlbr_estat", 14'h005, 32'h007F_0000);
    chk_csr("tlbr_era", 14'h006, 32'h1C00_0200);
    flush(1'b0, 1'b1, 32'h1C00_0200);
    chk_csr("tlbr_ertn_crmd", 14'h000, 32'h17);

    csr_ecode    = 6'h01;
    csr_esubcode = 9'h0;
    csr_era      = 32'h1C00_0300;
    flush(1'b1, 1'b1, 32'h1C00_8000);
    chk_csr("both_crmd", 14'h000, 32'h10);
    chk_csr("both_prmd", 14'h001, 32'h7);
    flush(1'b0, 1'b1, 32'h1C00_0300);
    chk_csr("b2b_ertn_crmd", 14'h000, 32'h17);
    repeat (3) tick();

    do_reset();
    wr(14'h004, 32'h4);
    wr(14'h000, 32'hC);
    chk("int_idle", {63'h0, has_int}, 64'h0);
    hw_int_in = 8'h01;
    tick();
    chk_csr("int_is_hw", 14'h005, 32'h4);
    chk("int_lat1", {63'h0, has_int}, 64'h0);
    tick();
    chk("int_lat2", {63'h0, has_int}, 64'h1);
    hw_int_in  = 8'h00;
    ipi_int_in = 1'b1;
    tick();
    tick();
    chk("int_masked", {63'h0, has_int}, 64'h0);
    chk_csr("int_is_ipi", 14'h005, 32'h1000);
    wr(14'h004, 32'h1000);
    tick();
    chk("int_ipi", {63'h0, has_int}, 64'h1);
    wr(14'h000, 32'h8);
    tick();
    chk("int_ie_off", {63'h0, has_int}, 64'h0);
    ipi_int_in = 1'b0;

    do_reset();
    wr(14'h004, 32'h800);
    wr(14'h000, 32'hC);
    wr(14'h041, 32'h13);
`ifdef CSR_TIMER_EN
    chk_csr("tval_load", 14'h042, 32'd16);
    chk_csr("tcfg_read", 14'h041, 32'h13);
    repeat (15) tick();
    chk_csr("tval_one", 14'h042, 32'd1);
    chk_csr("tmr_not_yet", 14'h005, 32'h0);
    tick();
    chk_csr("tmr_set", 14'h005, 32'h800);
    chk("tmr_int_lat", {63'h0, has_int}, 64'h0);
    wr(14'h044, 32'h1);
    chk("tmr_int", {63'h0, has_int}, 64'h1);
    chk_csr("ticlr_clear", 14'h005, 32'h0);
    chk_csr("tval_reload", 14'h042, 32'd16);
    tick();
    chk("tmr_int_gone", {63'h0, has_int}, 64'h0);
    chk_csr("tval_dec", 14'h042, 32'd15);
    repeat (14) tick();
    chk_csr("tval_one_again", 14'h042, 32'd1);
    wr(14'h044, 32'h1);
    chk_csr("set_wins", 14'h005, 32'h800);
    chk_csr("tval_zero", 14'h042, 32'd0);
    wr(14'h041, 32'h9);
    chk_csr("oneshot_load", 14'h042, 32'd8);
    repeat (12) tick();
    chk_csr("oneshot_hold", 14'h042, 32'd0);
`else
    repeat (20) tick();
    chk_csr("no_tmr_is11", 14'h005, 32'h0);
    chk_csr("no_tmr_tval", 14'h042, 32'h0);
    chk_csr("no_tmr_tcfg", 14'h041, 32'h0);
    chk("no_tmr_int", {63'h0, has_int}, 64'h0);
`endif

    chk("redirect_pending", 64'(rq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
